load_store_ctrl: RTL and testbench
==================================

LOAD_STORE_CTRL -- requirements
Module: load_store_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: mem_ack wait limit in cycles, range 1..255.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 ls_valid  in  1  CPU memory-op request; held by CPU while stall=1.
REQ-005 ls_we  in  1  1=store, 0=load.
REQ-006 ls_type  in  3  access type per ls_pkg encoding.
REQ-007 ls_addr  in  32  byte address.
REQ-008 ls_wdata  in  32  store data, low-aligned.
REQ-009 stall  out  1  freeze CPU pipeline.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 err  out  1  with done: misaligned or timed-out access.
REQ-012 rdata  out  32  extended load result, valid while done=1.
REQ-013 mem_req  out  1  memory request, held until mem_ack.
REQ-014 mem_we  out  1  memory write enable.
REQ-015 mem_be  out  4  byte enables.
REQ-016 mem_addr  out  32  word address: ls_addr with [1:0]=00.
REQ-017 mem_wdata  out  32  lane-replicated store data.
REQ-018 mem_rdata  in  32  read word, valid when mem_ack=1.
REQ-019 mem_ack  in  1  completion, one cycle, only while mem_req=1.

Function
REQ-020 FSM states IDLE, REQ, RESP; register captures we/type/addr/wdata on acceptance.
REQ-021 IDLE with ls_valid=1 and aligned: capture, go REQ; stall=1 that cycle (combinational).
REQ-022 Misaligned = half type with addr[0]=1, or word with addr[1:0]!=0; IDLE goes to RESP with err=1, no mem_req; stall=1 that cycle.
REQ-023 REQ: mem_req=1, stall=1; mem_ack=1 latches extended rdata, go RESP, err=0.
REQ-024 REQ: wait counter increments each cycle without ack; reaching TIMEOUT goes RESP with err=1, rdata=0.
REQ-025 RESP: done=1, stall=0, always returns to IDLE next cycle; ls_valid in RESP ignored.
REQ-026 Minimum latency: request accepted cycle N, ack cycle N+1, done cycle N+2.
REQ-027 mem_be: word 1111; half 0011 or 1100 by addr[1]; byte 0001 shifted left by addr[1:0].
REQ-028 mem_wdata: byte replicated x4, half replicated x2, word unchanged.
REQ-029 Load: select byte/half lane by captured addr, then sign-extend (B,H) or zero-extend (BU,HU); word passes through.
REQ-030 Undefined ls_type codes behave as word.
REQ-031 mem_we, mem_be, mem_addr, mem_wdata driven from capture register; mem_be=0000 outside REQ.
REQ-032 mem_ack outside REQ ignored.

Reset
REQ-033 rst_n=0 at a clock edge: state IDLE, counter 0, capture register 0.
REQ-034 Reset output values: stall 0 (unless ls_valid), done 0, err 0, rdata 0, mem_req 0, mem_we 0, mem_be 0000.
REQ-035 Reset during REQ abandons the access; mem_req low after that edge; late mem_ack ignored.

Structure
REQ-036 ls_pkg holds ls_type codes (W=0, B=1, BU=2, H=3, HU=4) and FSM state encoding.
REQ-037 One combinational sub-module load_align (rdata, addr[1:0], type -> extended word) instantiated once.

Verification
REQ-038 LB addr 0x103, mem_rdata 0x80123456, ack next cycle -> done at N+2, rdata 0xFFFFFF80, err 0.
REQ-039 SH addr 0x102, wdata 0x0000BEEF -> mem_be 1100, mem_wdata 0xBEEFBEEF, mem_addr 0x100, mem_we 1.
REQ-040 LW addr 0x101 -> no mem_req, done+err next cycle, stall low in RESP.
REQ-041 LHU addr 0x200, mem_ack withheld, TIMEOUT=4 -> err=1 done after 4 REQ cycles, rdata 0.
REQ-042 rst_n=0 during REQ, then mem_ack -> state IDLE, no done pulse, mem_req 0.
REQ-043 Back-to-back SB then LBU, ack each first REQ cycle -> two done pulses 3 cycles apart, correct be/rdata.

Source files
------------

// File: rtl/ls_pkg.sv
// Shared encodings and lane helpers for the load/store controller.
package ls_pkg;

  typedef enum logic [2:0] {
    LS_W  = 3'd0,
    LS_B  = 3'd1,
    LS_BU = 3'd2,
    LS_H  = 3'd3,
    LS_HU = 3'd4
  } ls_type_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  function automatic logic is_byte(logic [2:0] t);
    return (t == LS_B) || (t == LS_BU);
  endfunction

  function automatic logic is_half(logic [2:0] t);
    return (t == LS_H) || (t == LS_HU);
  endfunction

  // Undefined codes fall through to word rules.
  function automatic logic misaligned(logic [2:0] t, logic [1:0] a);
    if (is_byte(t)) return 1'b0;
    if (is_half(t)) return a[0];
    return a != 2'b00;
  endfunction

  function automatic logic [3:0] be_of(logic [2:0] t, logic [1:0] a);
    if (is_byte(t)) return 4'b0001 << a;
    if (is_half(t)) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] wdata_of(logic [2:0] t, logic [31:0] w);
    if (is_byte(t)) return {4{w[7:0]}};
    if (is_half(t)) return {2{w[15:0]}};
    return w;
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed lane from a read word and extends it to 32 bits.
module load_align
  import ls_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  ls_type,
  output logic [31:0] ext
);

  logic [31:0] sh;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    sh = word >> {off, 3'b000};
    b  = sh[7:0];
    h  = off[1] ? word[31:16] : word[15:0];
    unique case (1'b1)
      ls_type == LS_B:  ext = {{24{b[7]}}, b};
      ls_type == LS_BU: ext = {24'd0, b};
      ls_type == LS_H:  ext = {{16{h[15]}}, h};
      ls_type == LS_HU: ext = {16'd0, h};
      default:          ext = word;
    endcase
  end

endmodule

// File: rtl/load_store_ctrl.sv
// Single-outstanding load/store controller between the CPU and a
// request/ack memory port, with alignment checks and an ack timeout.
module load_store_ctrl
  import ls_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ls_valid,
  input  logic        ls_we,
  input  logic [2:0]  ls_type,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  type_q, type_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] ext;
  logic        mis;

  assign mis = misaligned(ls_type, ls_addr[1:0]);

  load_align u_align (
    .word    (mem_rdata),
    .off     (addr_q[1:0]),
    .ls_type (type_q),
    .ext     (ext)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    type_d  = type_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (ls_valid) begin
          we_d    = ls_we;
          type_d  = ls_type;
          addr_d  = ls_addr;
          wdata_d = ls_wdata;
          cnt_d   = 8'd0;
          rdata_d = 32'd0;
          err_d   = mis;
          state_d = mis ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (mem_ack) begin
          rdata_d = ext;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == TO_LAST) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      type_q  <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign stall     = ((state_q == S_IDLE) && ls_valid) || (state_q == S_REQ);
  assign done      = (state_q == S_RESP);
  assign err       = done && err_q;
  assign rdata     = rdata_q;
  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = we_q;
  assign mem_be    = mem_req ? be_of(type_q, addr_q[1:0]) : 4'b0000;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_of(type_q, wdata_q);

endmodule

// File: tb/tb_load_store_ctrl.sv
// Vector table plus scoreboard bench for load_store_ctrl with TIMEOUT=4.
module tb_load_store_ctrl;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        ls_valid = 0;
  logic        ls_we = 0;
  logic [2:0]  ls_type = 0;
  logic [31:0] ls_addr = 0;
  logic [31:0] ls_wdata = 0;
  logic        stall, done, err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 0;
  logic        mem_ack = 0;

  load_store_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ls_valid(ls_valid), .ls_we(ls_we), .ls_type(ls_type),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .stall(stall), .done(done), .err(err), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        we;
    logic [2:0]  ty;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] mrd;
    int          dly;
    logic        req;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic [31:0] rd;
    logic        er;
    int          lat;
  } vec_t;

  typedef struct packed {
    logic        er;
    logic [31:0] rd;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  vec_t v[14];
  int   done_at[14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic vec_t mk(logic we, logic [2:0] ty, logic [31:0] a,
      logic [31:0] wd, logic [31:0] mrd, int dly, logic req,
      logic [3:0] be, logic [31:0] ma, logic [31:0] mwd,
      logic [31:0] rd, logic er, int lat);
    vec_t r;
    r.we = we; r.ty = ty; r.addr = a; r.wd = wd; r.mrd = mrd;
    r.dly = dly; r.req = req; r.be = be; r.maddr = ma; r.mwd = mwd;
    r.rd = rd; r.er = er; r.lat = lat;
    return r;
  endfunction

  task automatic run(input vec_t t, input string nm, output int dcyc);
    bit   seen, got;
    exp_t e;
    seen = 0;
    got  = 0;
    dcyc = -1;
    @(negedge clk);
    ls_valid = 1; ls_we = t.we; ls_type = t.ty;
    ls_addr = t.addr; ls_wdata = t.wd;
    sb_q.push_back({t.er, t.rd});
    #1 chk({nm, ".stall_acc"}, 32'(stall), 32'd1);
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      mem_ack = 0;
      if (mem_req) begin
        if (!seen) begin
          chk({nm, ".be"}, 32'(mem_be), 32'(t.be));
          chk({nm, ".addr"}, mem_addr, t.maddr);
          chk({nm, ".wdata"}, mem_wdata, t.mwd);
          chk({nm, ".we"}, 32'(mem_we), 32'(t.we));
          seen = 1;
        end
        chk({nm, ".stall_req"}, 32'(stall), 32'd1);
        if (k - 1 == t.dly) begin
          mem_ack = 1;
          mem_rdata = t.mrd;
        end
      end
      if (done) begin
        got = 1;
        ls_valid = 0;
        dcyc = cyc;
        chk({nm, ".lat"}, 32'(k), 32'(t.lat));
        chk({nm, ".stall_resp"}, 32'(stall), 32'd0);
        chk({nm, ".be_resp"}, 32'(mem_be), 32'd0);
        if (sb_q.size() == 0) begin
          chk({nm, ".sb_empty_on_done"}, 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk({nm, ".err"}, 32'(err), 32'(e.er));
          chk({nm, ".rdata"}, rdata, e.rd);
        end
      end
    end
    chk({nm, ".req_seen"}, 32'(seen), 32'(t.req));
    if (!got) begin
      chk({nm, ".done_timeout"}, 32'd0, 32'd1);
      ls_valid = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    //        we  ty  addr   wdata        mrd          dly req be       maddr  mwd          rd           er lat
    v[0]  = mk(0, 1, 32'h103, 32'h0,        32'h80123456, 0, 1, 4'b1000, 32'h100, 32'h0,        32'hFFFFFF80, 0, 2);
    v[1]  = mk(1, 3, 32'h102, 32'h0000BEEF, 32'h0,        0, 1, 4'b1100, 32'h100, 32'hBEEFBEEF, 32'h0,        0, 2);
    v[2]  = mk(0, 0, 32'h101, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,   32'h0,        32'h0,        1, 1);
    v[3]  = mk(0, 4, 32'h200, 32'h0,        32'hDEADBEEF, 99, 1, 4'b0011, 32'h200, 32'h0,       32'h0,        1, 5);
    v[4]  = mk(1, 1, 32'h005, 32'h000000A5, 32'h0,        0, 1, 4'b0010, 32'h004, 32'hA5A5A5A5, 32'h0,        0, 2);
    v[5]  = mk(0, 2, 32'h006, 32'h0,        32'h12F45678, 0, 1, 4'b0100, 32'h004, 32'h0,        32'h000000F4, 0, 2);
    v[6]  = mk(0, 3, 32'h002, 32'h0,        32'h80017FFF, 2, 1, 4'b1100, 32'h000, 32'h0,        32'hFFFF8001, 0, 4);
    v[7]  = mk(0, 4, 32'h000, 32'h0,        32'h8001FFFE, 1, 1, 4'b0011, 32'h000, 32'h0,        32'h0000FFFE, 0, 3);
    v[8]  = mk(0, 0, 32'h010, 32'h0,        32'hCAFEF00D, 0, 1, 4'b1111, 32'h010, 32'h0,        32'hCAFEF00D, 0, 2);
    v[9]  = mk(1, 0, 32'h020, 32'h12345678, 32'h0,        0, 1, 4'b1111, 32'h020, 32'h12345678, 32'h0,        0, 2);
    v[10] = mk(0, 7, 32'h030, 32'h0,        32'h89ABCDEF, 0, 1, 4'b1111, 32'h030, 32'h0,        32'h89ABCDEF, 0, 2);
    v[11] = mk(0, 5, 32'h032, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,   32'h0,        32'h0,        1, 1);
    v[12] = mk(0, 3, 32'h001, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,   32'h0,        32'h0,        1, 1);
    v[13] = mk(0, 1, 32'h040, 32'h0,        32'h0000007F, 3, 1, 4'b0001, 32'h040, 32'h0,        32'h0000007F, 0, 5);

    repeat (3) @(negedge clk);
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    chk("rst.mem_req", 32'(mem_req), 32'd0);
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    chk("rst.mem_be", 32'(mem_be), 32'd0);
    rst_n = 1;

    for (int i = 0; i < 14; i++) begin
      run(v[i], $sformatf("v%0d", i), done_at[i]);
    end
    chk("b2b.gap", 32'(done_at[5] - done_at[4]), 32'd3);

    @(negedge clk);
    ls_valid = 1; ls_we = 1; ls_type = 0;
    ls_addr = 32'h50; ls_wdata = 32'h11;
    @(negedge clk);
    chk("rreq.mem_req", 32'(mem_req), 32'd1);
    chk("rreq.mem_we", 32'(mem_we), 32'd1);
    rst_n = 0;
    ls_valid = 0;
    @(negedge clk);
    chk("rreq.req_after", 32'(mem_req), 32'd0);
    chk("rreq.we_after", 32'(mem_we), 32'd0);
    chk("rreq.be_after", 32'(mem_be), 32'd0);
    chk("rreq.done_after", 32'(done), 32'd0);
    chk("rreq.stall_after", 32'(stall), 32'd0);
    rst_n = 1;
    mem_ack = 1;
    mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_ack = 0;
    chk("rreq.late_done", 32'(done), 32'd0);
    chk("rreq.late_req", 32'(mem_req), 32'd0);
    chk("rreq.late_rdata", rdata, 32'd0);
    chk("sb.empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
